can_bit_destuff: RTL and testbench

CAN receive-path bit destuffer. Sits between the bit sampler, which produces one sampled bit per nominal bit time, and the CRC-15 calculator. Inside the stuffed region (SOF through the end of the CRC sequence) it removes stuff bits and detects stuff errors. Outside that region it passes bits through unchanged. Its dout/dout_valid pair drives the CRC block's din/crc_en directly.

---
 rtl/can_pkg.sv | 18 +
 rtl/can_bit_destuff.sv | 159 +++++++++++++++
 tb/tb_can_bit_destuff.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/can_pkg.sv
// Shared CAN bit-level definitions used by the receive-path blocks.
package can_pkg;

  // Consecutive equal bits after which a complementary stuff bit is mandatory.
  localparam int CAN_STUFF_LEN = 5;

  // Destuffer state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_RUN       = 2'd1;
  localparam state_t ST_EXP_STUFF = 2'd2;
  localparam state_t ST_ERROR     = 2'd3;

  // Bus levels: dominant drives the bus low.
  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/can_bit_destuff.sv
// CAN receive-path bit destuffer. Removes stuff bits between SOF and the end
// of the CRC sequence, flags stuff-rule violations, and passes bits through
// unchanged outside the stuffed region. All outputs are registered, so every
// response appears one cycle after its bit_strobe.
module can_bit_destuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_strobe,
  input  logic             stuff_en,
  output logic             dout,
  output logic             dout_valid,
  output logic             stuff_drop,
  output logic             stuff_err,
  output logic             err_flag,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);

  state_t             state_q, state_d;
  logic [RUN_W-1:0]   cnt_q, cnt_d;
  logic               last_bit_q, last_bit_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               stuff_drop_q, stuff_drop_d;
  logic               stuff_err_q, stuff_err_d;
  logic               err_flag_q, err_flag_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

  // Run length including the current bit, as seen by a bit accepted in RUN.
  logic [RUN_W-1:0]   run_next;
  logic [CNT_W-1:0]   out_cnt_inc;

  assign run_next    = (bit_in == last_bit_q) ? cnt_q + 1'b1 : RUN_W'(1);
  assign out_cnt_inc = (out_cnt_q == {CNT_W{1'b1}}) ? out_cnt_q : out_cnt_q + 1'b1;

  // State and output registers; reset wins over a coincident strobe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_bit_q   <= RECESSIVE;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      stuff_drop_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      err_flag_q   <= 1'b0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_bit_q   <= last_bit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      stuff_drop_q <= stuff_drop_d;
      stuff_err_q  <= stuff_err_d;
      err_flag_q   <= err_flag_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

  // Next-state logic: only a strobe can move the FSM.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of
    // inferred latches when a case arm leaves the signal untouched.
    state_d = state_q;
    if (bit_strobe) begin
      unique case (state_q)
        ST_IDLE:      if (stuff_en) state_d = ST_RUN;
        ST_RUN: begin
          if (!stuff_en)                          state_d = ST_IDLE;
          else if (run_next == RUN_W'(STUFF_LEN)) state_d = ST_EXP_STUFF;
        end
        ST_EXP_STUFF: begin
          if (bit_in != last_bit_q) state_d = stuff_en ? ST_RUN : ST_IDLE;
          else                      state_d = ST_ERROR;
        end
        ST_ERROR:     if (!stuff_en) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values; pulses fall back to 0 on idle cycles.
  always_comb begin
    cnt_d        = cnt_q;
    last_bit_d   = last_bit_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    stuff_drop_d = 1'b0;
    stuff_err_d  = 1'b0;
    err_flag_d   = err_flag_q;
    out_cnt_d    = out_cnt_q;
    if (bit_strobe) begin
      unique case (state_q)
        ST_IDLE: begin
          dout_d       = bit_in;
          dout_valid_d = 1'b1;
          if (stuff_en) begin
            // SOF opens a new frame: fresh run, fresh count, error cleared.
            cnt_d      = RUN_W'(1);
            last_bit_d = bit_in;
            out_cnt_d  = CNT_W'(1);
            err_flag_d = 1'b0;
          end else begin
            cnt_d      = '0;
          end
        end
        ST_RUN: begin
          dout_d       = bit_in;
          dout_valid_d = 1'b1;
          if (stuff_en) begin
            cnt_d      = run_next;
            last_bit_d = bit_in;
            out_cnt_d  = out_cnt_inc;
          end else begin
            cnt_d      = '0;
          end
        end
        ST_EXP_STUFF: begin
          if (bit_in != last_bit_q) begin
            // The stuff bit itself starts the next run.
            stuff_drop_d = 1'b1;
            last_bit_d   = bit_in;
            cnt_d        = stuff_en ? RUN_W'(1) : '0;
          end else begin
            stuff_err_d  = 1'b1;
            err_flag_d   = 1'b1;
            cnt_d        = '0;
          end
        end
        ST_ERROR: begin
          if (!stuff_en) begin
            dout_d       = bit_in;
            dout_valid_d = 1'b1;
            cnt_d        = '0;
          end
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign stuff_drop = stuff_drop_q;
  assign stuff_err  = stuff_err_q;
  assign err_flag   = err_flag_q;
  assign out_cnt    = out_cnt_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Testbench for can_bit_destuff: hand-derived vector table, a reset corner
// sequence, and a randomized run against a history-based reference model.
module tb_can_bit_destuff;

  localparam int STUFF_LEN = 5;
  localparam int CNT_W     = 7;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bit_in = 1'b1;
  logic             bit_strobe = 1'b0;
  logic             stuff_en = 1'b0;
  logic             dout, dout_valid, stuff_drop, stuff_err, err_flag;
  logic [CNT_W-1:0] out_cnt;

  int errors = 0;
  int checks = 0;

  can_bit_destuff #(.STUFF_LEN(STUFF_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_strobe(bit_strobe),
    .stuff_en(stuff_en), .dout(dout), .dout_valid(dout_valid),
    .stuff_drop(stuff_drop), .stuff_err(stuff_err), .err_flag(err_flag),
    .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bit_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One strobe; returns with outputs settled half a cycle after the capture edge.
  task automatic drive(input bit b, input bit en);
    @(negedge clk);
    bit_in = b;
    stuff_en = en;
    bit_strobe = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  // Pulses must be gone on the cycle after a strobe response.
  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, " idle pulses"}, {29'd0, dout_valid, stuff_drop, stuff_err}, 32'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit do_rst;
    bit b;
    bit en;
    bit v;
    bit d;
    bit drop;
    bit err;
    bit flag;
    int cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit r, bit b, bit en, bit v, bit d, bit drop, bit err,
                              bit flag, int cnt);
    vec_t e;
    e.do_rst = r; e.b = b; e.en = en; e.v = v; e.d = d;
    e.drop = drop; e.err = err; e.flag = flag; e.cnt = cnt;
    tbl.push_back(e);
  endfunction

  // ---------------- reference model ----------------
  // Keeps the accepted bit history of the current frame; a stuff bit is due
  // whenever the last STUFF_LEN accepted bits are all equal.
  bit m_hist[$];
  bit m_in_frame;
  bit m_errored;
  bit m_flag;
  int m_emitted;

  function automatic void model_reset();
    m_hist.delete();
    m_in_frame = 0;
    m_errored  = 0;
    m_flag     = 0;
    m_emitted  = 0;
  endfunction

  function automatic bit stuff_due();
    int n = m_hist.size();
    if (!m_in_frame || n < STUFF_LEN) return 0;
    for (int i = n - STUFF_LEN; i < n; i++)
      if (m_hist[i] != m_hist[n-1]) return 0;
    return 1;
  endfunction

  function automatic void push_hist(bit b);
    m_hist.push_back(b);
    if (m_hist.size() > 2 * STUFF_LEN) void'(m_hist.pop_front());
  endfunction

  function automatic void model_step(input bit b, input bit en,
                                     output bit v, output bit d, output bit drop,
                                     output bit err);
    v = 0; d = b; drop = 0; err = 0;
    if (m_errored) begin
      if (!en) begin v = 1; m_errored = 0; end
    end else if (stuff_due()) begin
      if (b != m_hist[m_hist.size()-1]) begin
        drop = 1;
        push_hist(b);
        if (!en) m_in_frame = 0;
      end else begin
        err = 1; m_flag = 1; m_errored = 1; m_in_frame = 0;
      end
    end else if (m_in_frame) begin
      v = 1;
      if (en) begin push_hist(b); m_emitted++; end
      else m_in_frame = 0;
    end else begin
      v = 1;
      if (en) begin
        m_hist.delete();
        push_hist(b);
        m_in_frame = 1;
        m_emitted = 1;
        m_flag = 0;
      end
    end
  endfunction

  initial begin
    bit v, d, drop, err, last_b, en;
    int sat;

    // Plan 1: pass-through outside the stuffed region.
    for (int i = 0; i < 10; i++) add(i == 0, 1, 0, 1, 1, 0, 0, 0, 0);
    // Plan 2: five dominant bits, recessive stuff bit dropped, data resumes.
    add(1, 0, 1, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 2);
    add(0, 0, 1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 1, 1, 0, 0, 0, 0, 4);
    add(0, 0, 1, 1, 0, 0, 0, 0, 5);
    add(0, 1, 1, 0, 0, 1, 0, 0, 5);
    add(0, 0, 1, 1, 0, 0, 0, 0, 6);
    // Plan 3: sixth equal bit is a stuff error; ERROR swallows bits.
    add(1, 1, 1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 2 + i);
    add(0, 0, 1, 0, 0, 0, 1, 1, 6);
    add(0, 1, 1, 0, 0, 0, 0, 1, 6);
    add(0, 1, 1, 0, 0, 0, 0, 1, 6);
    add(0, 1, 0, 1, 1, 0, 0, 1, 6);
    add(0, 0, 0, 1, 0, 0, 0, 1, 6);   // still IDLE: plain pass-through
    add(0, 0, 1, 1, 0, 0, 0, 0, 1);   // new SOF clears err_flag
    // Plan 4: stuff bit after the region ends is still removed.
    add(1, 0, 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 1, 0, 0, 0, 2 + i);
    add(0, 0, 0, 0, 0, 1, 0, 0, 6);
    add(0, 1, 0, 1, 1, 0, 0, 0, 6);
    // Plan 5: alternating bits never stuff; long frame saturates out_cnt.
    for (int i = 0; i < 135; i++) begin
      sat = (i + 1 > CNT_MAX) ? CNT_MAX : i + 1;
      add(i == 0, bit'(i % 2), 1, 1, bit'(i % 2), 0, 0, 0, sat);
    end

    do_reset();
    check("reset dout_valid", dout_valid, 0);
    check("reset dout", dout, 0);
    check("reset err_flag", err_flag, 0);
    check("reset out_cnt", out_cnt, 0);

    foreach (tbl[k]) begin
      if (tbl[k].do_rst) do_reset();
      drive(tbl[k].b, tbl[k].en);
      check($sformatf("vec%0d dout_valid", k), dout_valid, tbl[k].v);
      if (tbl[k].v) check($sformatf("vec%0d dout", k), dout, tbl[k].d);
      check($sformatf("vec%0d stuff_drop", k), stuff_drop, tbl[k].drop);
      check($sformatf("vec%0d stuff_err", k), stuff_err, tbl[k].err);
      check($sformatf("vec%0d err_flag", k), err_flag, tbl[k].flag);
      check($sformatf("vec%0d out_cnt", k), out_cnt, tbl[k].cnt);
    end
    check_idle("table");

    // Plan 6: reset while a stuff bit is expected, coincident with a strobe.
    do_reset();
    for (int i = 0; i < 5; i++) drive(0, 1);
    check("p6 pre-reset out_cnt", out_cnt, 5);
    @(negedge clk);
    bit_in = 1'b1; stuff_en = 1'b1; bit_strobe = 1'b1; rst = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0; rst = 1'b0;
    check("p6 outputs after rst",
          {26'd0, dout, dout_valid, stuff_drop, stuff_err, err_flag, 1'b0}, 32'd0);
    check("p6 out_cnt after rst", out_cnt, 0);
    drive(0, 0);
    check("p6 pass dout_valid", dout_valid, 1);
    check("p6 pass dout", dout, 0);
    check("p6 pass stuff_drop", stuff_drop, 0);

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    last_b = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        model_reset();
      end
      last_b = ($urandom_range(0, 9) < 8) ? last_b : ~last_b;
      en = ($urandom_range(0, 24) != 0);
      drive(last_b, en);
      model_step(last_b, en, v, d, drop, err);
      sat = (m_emitted > CNT_MAX) ? CNT_MAX : m_emitted;
      check($sformatf("rnd%0d dout_valid", n), dout_valid, v);
      if (v) check($sformatf("rnd%0d dout", n), dout, d);
      check($sformatf("rnd%0d stuff_drop", n), stuff_drop, drop);
      check($sformatf("rnd%0d stuff_err", n), stuff_err, err);
      check($sformatf("rnd%0d err_flag", n), err_flag, m_flag);
      if (m_in_frame || m_errored || err)
        check($sformatf("rnd%0d out_cnt", n), out_cnt, sat);
      if (n % 50 == 0) check_idle($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
